// File: rtl/wb_trace_checker.sv
// Write-back trace checker: compares retired register writes against a queue of expected
// {addr, data} events. Define WB_CHECK_PC_EN to also store and compare the expected PC.
module wb_trace_checker #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              exp_valid_i,
  output logic              exp_ready_o,
  input  logic [ADDR_W-1:0] exp_addr_i,
  input  logic [DATA_W-1:0] exp_data_i,
  input  logic [PC_W-1:0]   exp_pc_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [PC_W-1:0]   wb_pc_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  pass_cnt_o,
  output logic [CNT_W-1:0]  total_cnt_o,
  output logic [CNT_W-1:0]  unexp_cnt_o,
  output logic              fail_flag_o,
  output logic [CNT_W-1:0]  fail_index_o,
  output logic [PC_W-1:0]   fail_pc_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]   pass_q, pass_d, total_q, total_d, unexp_q, unexp_d;
  logic [CNT_W-1:0]   fail_index_q, fail_index_d;
  logic               fail_flag_q, fail_flag_d;
  logic [PC_W-1:0]    fail_pc_q, fail_pc_d;

  logic [ADDR_W-1:0]  mem_addr_q [DEPTH];
  logic [DATA_W-1:0]  mem_data_q [DEPTH];
  logic               exp_ready_s, push_s, pop_s, head_match_s;

  assign exp_ready_s = (occ_q != OCC_FULL) && (state_q != ST_DONE);
  assign push_s      = exp_valid_i && exp_ready_s;
  assign pop_s       = (state_q == ST_RUN) && wb_valid_i && (occ_q != '0);

`ifdef WB_CHECK_PC_EN
  logic [PC_W-1:0] mem_pc_q [DEPTH];

  // Expected-PC storage, written alongside addr/data.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_pc_q[wr_ptr_q] <= exp_pc_i;
  end

  assign head_match_s = (wb_addr_i == mem_addr_q[rd_ptr_q]) &&
                        (wb_data_i == mem_data_q[rd_ptr_q]) &&
                        (wb_pc_i   == mem_pc_q[rd_ptr_q]);
`else
  logic unused_exp_pc_s;
  assign unused_exp_pc_s = ^exp_pc_i;
  assign head_match_s = (wb_addr_i == mem_addr_q[rd_ptr_q]) &&
                        (wb_data_i == mem_data_q[rd_ptr_q]);
`endif

  // Expected-event payload storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_addr_q[wr_ptr_q] <= exp_addr_i;
      mem_data_q[wr_ptr_q] <= exp_data_i;
    end
  end

  // Next-state: queue bookkeeping, FSM transitions, compare and saturating counters.
  always_comb begin
    state_d      = state_q;
    pass_d       = pass_q;
    total_d      = total_q;
    unexp_d      = unexp_q;
    fail_flag_d  = fail_flag_q;
    fail_index_d = fail_index_q;
    fail_pc_d    = fail_pc_q;
    wr_ptr_d     = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d        = occ_q + OCC_W'(push_s) - OCC_W'(pop_s);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // A start that leaves nothing to check completes straight away.
          state_d = ((occ_d == '0) && !push_s) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (pop_s) begin
          total_d = sat_inc(total_q);
          if (head_match_s) begin
            pass_d = sat_inc(pass_q);
          end else begin
            fail_flag_d = 1'b1;
            if (!fail_flag_q) begin
              fail_index_d = total_q;
              fail_pc_d    = wb_pc_i;
            end else begin
              fail_index_d = fail_index_q;
            end
          end
        end else if (wb_valid_i) begin
          unexp_d = sat_inc(unexp_q);
        end else begin
          unexp_d = unexp_q;
        end
        state_d = ((occ_d == '0) && !push_s) ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        if (wb_valid_i) begin
          unexp_d = sat_inc(unexp_q);
        end else begin
          unexp_d = unexp_q;
        end
        if (start_i) begin
          state_d      = ST_IDLE;
          pass_d       = '0;
          total_d      = '0;
          unexp_d      = '0;
          fail_flag_d  = 1'b0;
          fail_index_d = '0;
          fail_pc_d    = '0;
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          occ_d        = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      pass_q       <= '0;
      total_q      <= '0;
      unexp_q      <= '0;
      fail_flag_q  <= 1'b0;
      fail_index_q <= '0;
      fail_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      pass_q       <= pass_d;
      total_q      <= total_d;
      unexp_q      <= unexp_d;
      fail_flag_q  <= fail_flag_d;
      fail_index_q <= fail_index_d;
      fail_pc_q    <= fail_pc_d;
    end
  end

  assign exp_ready_o  = exp_ready_s;
  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign pass_cnt_o   = pass_q;
  assign total_cnt_o  = total_q;
  assign unexp_cnt_o  = unexp_q;
  assign fail_flag_o  = fail_flag_q;
  assign fail_index_o = fail_index_q;
  assign fail_pc_o    = fail_pc_q;

endmodule
